// File: rtl/dcache_pkg.sv
// Shared constants and types for the dcache flush controller and its memory port mux.
package dcache_pkg;

    localparam int unsigned NUM_LINES     = 32;
    localparam int unsigned IDX_W         = 5;
    localparam int unsigned TAG_W         = 24;
    localparam int unsigned LINE_W        = 256;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned OFFSET_W      = 5;
    localparam int unsigned TAG_VALID_BIT = 23;
    localparam int unsigned TAG_DIRTY_BIT = 22;
    localparam int unsigned TAG_ADDR_W    = 22;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        FL_IDLE,
        FL_WAIT_IDLE,
        FL_SCAN,
        FL_WRITE,
        FL_CLEAR,
        FL_NEXT,
        FL_DONE
    } flush_state_e;

    typedef enum logic {
        OWN_DC,
        OWN_FL
    } owner_e;

    // Byte address of a cache line rebuilt from its stored tag and its index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_ADDR_W-1:0] tag,
                                                    input logic [IDX_W-1:0]      idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_flush_ctrl_if.sv
// Single 256-bit Data_Memory port: request held until a one-cycle ack.
interface dcache_flush_ctrl_if;
    import dcache_pkg::*;

    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              ack;
    logic [LINE_W-1:0] rdata;

    modport master (output enable, output write, output addr, output wdata,
                    input  ack,    input  rdata);
    modport slave  (input  enable, input  write, input  addr, input  wdata,
                    output ack,    output rdata);

endinterface

// File: rtl/mem_port_mux.sv
// 2:1 request mux for the shared memory port; ack is steered to the current owner only.
module mem_port_mux
    import dcache_pkg::*;
(
    input  owner_e             owner_i,
    input  logic               fl_enable_i,
    input  logic               fl_write_i,
    input  logic [ADDR_W-1:0]  fl_addr_i,
    input  logic [LINE_W-1:0]  fl_data_i,
    output logic               fl_ack_o,
    input  logic               dc_mem_enable_i,
    input  logic               dc_mem_write_i,
    input  logic [ADDR_W-1:0]  dc_mem_addr_i,
    input  logic [LINE_W-1:0]  dc_mem_data_i,
    output logic               dc_mem_ack_o,
    output logic [LINE_W-1:0]  dc_mem_data_o,
    dcache_flush_ctrl_if.master mem
);

    // Forward the owner's request; a non-owner request simply stays pending upstream.
    always_comb begin
        mem.enable = dc_mem_enable_i;
        mem.write  = dc_mem_write_i;
        mem.addr   = dc_mem_addr_i;
        mem.wdata  = dc_mem_data_i;
        if (owner_i == OWN_FL) begin
            mem.enable = fl_enable_i;
            mem.write  = fl_write_i;
            mem.addr   = fl_addr_i;
            mem.wdata  = fl_data_i;
        end
    end

    assign fl_ack_o      = (owner_i == OWN_FL) && mem.ack;
    assign dc_mem_ack_o  = (owner_i == OWN_DC) && mem.ack;
    assign dc_mem_data_o = mem.rdata;

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Hardware flush sequencer for the direct-mapped dcache: writes back valid+dirty
// lines through the shared memory port and clears their dirty bits.
module dcache_flush_ctrl
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_req_i,
    output logic               flush_busy_o,
    output logic               flush_done_o,
    output logic               cache_hold_o,
    input  logic               dc_idle_i,
    output logic [IDX_W-1:0]   sram_idx_o,
    input  logic [TAG_W-1:0]   sram_tag_i,
    input  logic [LINE_W-1:0]  sram_data_i,
    output logic               sram_tag_we_o,
    output logic [TAG_W-1:0]   sram_tag_o,
    input  logic               dc_mem_enable_i,
    input  logic               dc_mem_write_i,
    input  logic [ADDR_W-1:0]  dc_mem_addr_i,
    input  logic [LINE_W-1:0]  dc_mem_data_i,
    output logic               dc_mem_ack_o,
    output logic [LINE_W-1:0]  dc_mem_data_o,
    dcache_flush_ctrl_if.master mem
);

    flush_state_e            state_q, state_d;
    owner_e                  owner_q, owner_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0]       wb_addr_q, wb_addr_d;
    logic [LINE_W-1:0]       wb_data_q, wb_data_d;
    logic [TAG_ADDR_W-1:0]   wb_tag_q, wb_tag_d;
    logic                    fl_enable;
    logic                    fl_ack;
    logic                    line_dirty;

    assign line_dirty = sram_tag_i[TAG_VALID_BIT] && sram_tag_i[TAG_DIRTY_BIT];

    // State, ownership and write-back latches; reset aborts any flush immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= FL_IDLE;
            owner_q   <= OWN_DC;
            idx_q     <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_tag_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            idx_q     <= idx_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_tag_q  <= wb_tag_d;
        end
    end

    // Next-state logic: line walk, write-back, dirty clear and port ownership handover.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        idx_d     = idx_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_tag_d  = wb_tag_q;
        unique case (state_q)
            FL_IDLE: begin
                if (flush_req_i) state_d = FL_WAIT_IDLE;
            end
            FL_WAIT_IDLE: begin
                // With owner DC the port enable equals dc_mem_enable_i, so this is
                // also the "port quiet" condition for the ownership switch.
                if (dc_idle_i && !dc_mem_enable_i) begin
                    state_d = FL_SCAN;
                    owner_d = OWN_FL;
                end
            end
            FL_SCAN: begin
                if (line_dirty) begin
                    wb_tag_d  = sram_tag_i[TAG_ADDR_W-1:0];
                    wb_addr_d = line_addr(sram_tag_i[TAG_ADDR_W-1:0], idx_q);
                    wb_data_d = sram_data_i;
                    state_d   = FL_WRITE;
                end else begin
                    state_d   = FL_NEXT;
                end
            end
            FL_WRITE: begin
                if (fl_ack) state_d = FL_CLEAR;
            end
            FL_CLEAR: begin
                state_d = FL_NEXT;
            end
            FL_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FL_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FL_SCAN;
                end
            end
            FL_DONE: begin
                owner_d = OWN_DC;
                idx_d   = '0;
                state_d = FL_IDLE;
            end
            default: state_d = FL_IDLE;
        endcase
    end

    assign fl_enable     = (state_q == FL_WRITE);
    assign flush_busy_o  = (state_q != FL_IDLE) && (state_q != FL_DONE);
    assign flush_done_o  = (state_q == FL_DONE);
    assign cache_hold_o  = (state_q != FL_IDLE);
    assign sram_idx_o    = idx_q;
    assign sram_tag_we_o = (state_q == FL_CLEAR);
    assign sram_tag_o    = sram_tag_we_o ? {1'b1, 1'b0, wb_tag_q} : '0;

    mem_port_mux u_mux (
        .owner_i         (owner_q),
        .fl_enable_i     (fl_enable),
        .fl_write_i      (fl_enable),
        .fl_addr_i       (wb_addr_q),
        .fl_data_i       (wb_data_q),
        .fl_ack_o        (fl_ack),
        .dc_mem_enable_i (dc_mem_enable_i),
        .dc_mem_write_i  (dc_mem_write_i),
        .dc_mem_addr_i   (dc_mem_addr_i),
        .dc_mem_data_i   (dc_mem_data_i),
        .dc_mem_ack_o    (dc_mem_ack_o),
        .dc_mem_data_o   (dc_mem_data_o),
        .mem             (mem)
    );

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl with tag/data SRAM and Data_Memory models.
module tb_dcache_flush_ctrl;
    import dcache_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush_req = 1'b0;
    logic              flush_busy, flush_done, cache_hold;
    logic              dc_idle = 1'b1;
    logic [IDX_W-1:0]  sram_idx;
    logic [TAG_W-1:0]  sram_tag_r, sram_tag_w;
    logic [LINE_W-1:0] sram_data;
    logic              sram_tag_we;
    logic              dc_en = 1'b0, dc_wr = 1'b0;
    logic [ADDR_W-1:0] dc_addr = '0;
    logic [LINE_W-1:0] dc_wdata = '0;
    logic              dc_ack;
    logic [LINE_W-1:0] dc_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcache_flush_ctrl_if mif ();

    dcache_flush_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .flush_req_i     (flush_req),
        .flush_busy_o    (flush_busy),
        .flush_done_o    (flush_done),
        .cache_hold_o    (cache_hold),
        .dc_idle_i       (dc_idle),
        .sram_idx_o      (sram_idx),
        .sram_tag_i      (sram_tag_r),
        .sram_data_i     (sram_data),
        .sram_tag_we_o   (sram_tag_we),
        .sram_tag_o      (sram_tag_w),
        .dc_mem_enable_i (dc_en),
        .dc_mem_write_i  (dc_wr),
        .dc_mem_addr_i   (dc_addr),
        .dc_mem_data_i   (dc_wdata),
        .dc_mem_ack_o    (dc_ack),
        .dc_mem_data_o   (dc_rdata),
        .mem             (mif)
    );

    // Tag/data SRAM: combinational read, synchronous tag write, bench preload port.
    logic [TAG_W-1:0]  tags  [NUM_LINES];
    logic [LINE_W-1:0] lines [NUM_LINES];
    logic              ld_en = 1'b0;
    logic [IDX_W-1:0]  ld_idx = '0;
    logic [TAG_W-1:0]  ld_tag = '0;
    logic [LINE_W-1:0] ld_data = '0;

    assign sram_tag_r = tags[sram_idx];
    assign sram_data  = lines[sram_idx];

    always @(posedge clk) begin
        if (sram_tag_we) tags[sram_idx] <= sram_tag_w;
        if (ld_en) begin
            tags[ld_idx]  <= ld_tag;
            lines[ld_idx] <= ld_data;
        end
    end

    // Data_Memory: ack one-cycle pulse after mem_lat waiting cycles; writes logged.
    int                mem_lat = 3;
    int                mcnt = 0;
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [LINE_W-1:0] wr_data_q [$];

    assign mif.rdata = {8{mif.addr}};

    always @(posedge clk) begin
        if (mif.enable && !mif.ack) begin
            if (mcnt == mem_lat) begin
                mif.ack <= 1'b1;
                mcnt    <= 0;
                if (mif.write) begin
                    wr_addr_q.push_back(mif.addr);
                    wr_data_q.push_back(mif.wdata);
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mif.ack <= 1'b0;
            mcnt    <= 0;
        end
    end

    int done_cnt = 0;
    int dc_ack_cnt = 0;
    always @(negedge clk) begin
        if (flush_done) done_cnt++;
        if (dc_ack) dc_ack_cnt++;
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int unsigned idx, input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_idx  = IDX_W'(idx);
        ld_tag  = tag;
        ld_data = data;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Returns the number of negedges until flush_done is seen, or -1 on timeout.
    task automatic run_until_done(input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (flush_done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    int cyc;
    int nw;
    int dcnt;
    int acnt;
    bit seen;

    initial begin
        for (int unsigned i = 0; i < NUM_LINES; i++)
            load(i, 24'h000000, {8{i}});

        // Reset state
        @(negedge clk);
        chk("rst_busy", flush_busy, 1'b0);
        chk("rst_done", flush_done, 1'b0);
        chk("rst_hold", cache_hold, 1'b0);
        chk("rst_idx", sram_idx, 0);
        chk("rst_tag_we", sram_tag_we, 1'b0);
        chk("rst_mem_en", mif.enable, 1'b0);
        chk("rst_dc_ack", dc_ack, 1'b0);
        rst_n = 1'b1;

        // 1: all clean; req seen at edge 1, DONE observed in cycle 66
        pulse_flush();
        chk("t1_busy_c1", flush_busy, 1'b1);
        chk("t1_hold_c1", cache_hold, 1'b1);
        run_until_done(200, cyc);
        chk("t1_done_cycle", cyc + 1, 66);
        chk("t1_idx_at_done", sram_idx, 31);
        @(negedge clk);
        chk("t1_hold_dropped", cache_hold, 1'b0);
        chk("t1_idx_back", sram_idx, 0);
        chk("t1_no_writes", wr_addr_q.size(), 0);

        // 2: line 3 dirty, DC write request raised mid-flush stays pending
        load(3, 24'hC00005, {32{8'hAB}});
        acnt = dc_ack_cnt;
        pulse_flush();
        repeat (4) @(negedge clk);
        dc_idle  = 1'b0;
        dc_en    = 1'b1;
        dc_wr    = 1'b1;
        dc_addr  = 32'h0000_7700;
        dc_wdata = {8{32'h5A5A_0001}};
        run_until_done(400, cyc);
        chk("t2_done_seen", cyc >= 0, 1'b1);
        chk("t2_dc_held", dc_ack_cnt - acnt, 0);
        chk("t2_nwrites", wr_addr_q.size(), 1);
        // {tag[21:0]=0x5, idx=3, 5'b0} = 0x1460
        chk("t2_wb_addr", wr_addr_q[0], 32'h0000_1460);
        chk("t2_wb_data", wr_data_q[0], {32{8'hAB}});
        chk("t2_tag_clean", tags[3], 24'h800005);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dc_ack) seen = 1'b1;
        end
        chk("t2_dc_served", seen, 1'b1);
        dc_en   = 1'b0;
        dc_wr   = 1'b0;
        dc_idle = 1'b1;
        chk("t2_dc_after", wr_addr_q.size(), 2);
        chk("t2_dc_addr", wr_addr_q[wr_addr_q.size()-1], 32'h0000_7700);

        // 3: lines 0 and 31 dirty, line 10 invalid+dirty skipped; 2 dirty lines add 2*6 cycles
        load(0, 24'hC0ABCD, {8{32'h0000_C0DE}});
        load(31, 24'hC00001, {8{32'h3131_3131}});
        load(10, 24'h400777, {8{32'h1010_1010}});
        nw = wr_addr_q.size();
        pulse_flush();
        run_until_done(400, cyc);
        chk("t3_done_cycle", cyc + 1, 78);
        chk("t3_nwrites", wr_addr_q.size() - nw, 2);
        chk("t3_addr_first", wr_addr_q[nw], 32'h02AF_3400);
        chk("t3_addr_second", wr_addr_q[nw+1], 32'h0000_07E0);
        chk("t3_data_second", wr_data_q[nw+1], {8{32'h3131_3131}});
        chk("t3_tag0", tags[0], 24'h80ABCD);
        chk("t3_tag31", tags[31], 24'h800001);
        chk("t3_tag10_kept", tags[10], 24'h400777);
        @(negedge clk);
        chk("t3_idx_back", sram_idx, 0);

        // 4: DC read miss in flight when flush requested
        @(negedge clk);
        dc_idle   = 1'b0;
        dc_en     = 1'b1;
        dc_wr     = 1'b0;
        dc_addr   = 32'h0001_2340;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        chk("t4_busy", flush_busy, 1'b1);
        chk("t4_fwd_en", mif.enable, 1'b1);
        chk("t4_fwd_addr", mif.addr, 32'h0001_2340);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (dc_ack) seen = 1'b1;
            else @(negedge clk);
        end
        chk("t4_dc_ack", seen, 1'b1);
        chk("t4_dc_rdata", dc_rdata, {8{32'h0001_2340}});
        dc_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_still_wait", flush_busy, 1'b1);
        chk("t4_no_clear", sram_tag_we, 1'b0);
        nw = wr_addr_q.size();
        dc_idle = 1'b1;
        run_until_done(300, cyc);
        chk("t4_done_cycle", cyc, 65);
        chk("t4_no_writes", wr_addr_q.size() - nw, 0);

        // 5: reset while writing line 7
        load(2, 24'hC00022, {8{32'h2222_2222}});
        load(7, 24'hC00033, {8{32'h7777_7777}});
        mem_lat = 10;
        nw = wr_addr_q.size();
        pulse_flush();
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (mif.enable && sram_idx == 7) seen = 1'b1;
        end
        chk("t5_reached_wr7", seen, 1'b1);
        chk("t5_tag2_clean", tags[2], 24'h800022);
        rst_n = 1'b0;
        #1;
        chk("t5_en_drop", mif.enable, 1'b0);
        chk("t5_busy", flush_busy, 1'b0);
        chk("t5_hold", cache_hold, 1'b0);
        chk("t5_idx", sram_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("t5_tag7_dirty", tags[7], 24'hC00033);
        chk("t5_nwrites", wr_addr_q.size() - nw, 1);
        chk("t5_idle_after", cache_hold, 1'b0);
        mem_lat = 3;

        // 6: re-request during flush ignored
        load(5, 24'hC00044, {8{32'h5555_5555}});
        nw   = wr_addr_q.size();
        dcnt = done_cnt;
        pulse_flush();
        repeat (20) @(negedge clk);
        flush_req = 1'b1;
        repeat (10) @(negedge clk);
        flush_req = 1'b0;
        run_until_done(300, cyc);
        chk("t6_done_seen", cyc >= 0, 1'b1);
        repeat (150) @(negedge clk);
        chk("t6_one_done", done_cnt - dcnt, 1);
        chk("t6_hold", cache_hold, 1'b0);
        // line 7 was left dirty by the aborted flush and is written here too
        chk("t6_nwrites", wr_addr_q.size() - nw, 2);
        chk("t6_tag5", tags[5], 24'h800044);
        chk("t6_tag7", tags[7], 24'h800033);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
